// File: rtl/exmem_buffer.sv
// exmem_buffer -- LEGv8 execute-to-memory pipeline buffer.
//
// Captures the ALU result, zero flag, store data, destination register and
// memory/writeback control bits from execute under a valid/ready handshake.
// It holds them for the memory stage, so a stalled memory access
// back-pressures execute without losing an entry. It also produces the CBZ
// branch-taken decision from the buffered zero flag.
//
// Build option: EXMEM_SKID_EN
//   defined   - two entries (main + skid); in_ready comes from registers only.
//   undefined - one entry; in_ready depends combinationally on out_ready.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   flush          synchronous squash of all buffered entries
//   in_valid       execute presents an entry
//   in_ready       buffer can accept an entry this cycle
//   in_result      ALU result (N bits)
//   in_zero        ALU zero flag
//   in_writedata   store data (N bits)
//   in_rd          destination register (5 bits)
//   in_regwrite, in_memread, in_memwrite, in_branch   control bits
//   out_valid      entry presented to the memory stage
//   out_ready      memory stage accepts the entry this cycle
//   out_result, out_writedata, out_zero, out_rd       buffered payload
//   out_regwrite, out_memread, out_memwrite, out_branch  buffered control
//   out_take       out_valid & out_branch & out_zero (CBZ taken)
module exmem_buffer #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_result,
    input  logic         in_zero,
    input  logic [N-1:0] in_writedata,
    input  logic [4:0]   in_rd,
    input  logic         in_regwrite,
    input  logic         in_memread,
    input  logic         in_memwrite,
    input  logic         in_branch,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic [N-1:0] out_writedata,
    output logic         out_zero,
    output logic [4:0]   out_rd,
    output logic         out_regwrite,
    output logic         out_memread,
    output logic         out_memwrite,
    output logic         out_branch,
    output logic         out_take
);

    typedef struct packed {
        logic [N-1:0] result;
        logic         zero;
        logic [N-1:0] writedata;
        logic [4:0]   rd;
        logic         regwrite;
        logic         memread;
        logic         memwrite;
        logic         branch;
    } entry_t;

    entry_t in_e;
    entry_t main_q;
    logic   main_v;
    logic   in_xfer;
    logic   out_xfer;

    assign in_e = '{result:    in_result,
                    zero:      in_zero,
                    writedata: in_writedata,
                    rd:        in_rd,
                    regwrite:  in_regwrite,
                    memread:   in_memread,
                    memwrite:  in_memwrite,
                    branch:    in_branch};

    // A flush cycle blocks both transfers; the entries are dropped at the edge.
    assign out_valid = main_v & ~flush;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

`ifdef EXMEM_SKID_EN
    entry_t skid_q;
    logic   skid_v;

    // Ready depends only on the skid register, which breaks the out_ready
    // to in_ready path; the skid absorbs the entry accepted while main stalls.
    assign in_ready = ~flush & ~skid_v;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (out_xfer) begin
            if (skid_v) begin
                main_q <= skid_q;
                main_v <= 1'b1;
                skid_v <= in_xfer;
                if (in_xfer) begin
                    skid_q <= in_e;
                end
            end else begin
                main_v <= in_xfer;
                if (in_xfer) begin
                    main_q <= in_e;
                end
            end
        end else if (in_xfer) begin
            if (!main_v) begin
                main_q <= in_e;
                main_v <= 1'b1;
            end else begin
                skid_q <= in_e;
                skid_v <= 1'b1;
            end
        end
    end
`else
    assign in_ready = ~flush & (~main_v | out_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_v <= 1'b0;
            main_q <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
        end else if (in_xfer) begin
            main_q <= in_e;
            main_v <= 1'b1;
        end else if (out_xfer) begin
            main_v <= 1'b0;
        end
    end
`endif

    assign out_result    = main_q.result;
    assign out_zero      = main_q.zero;
    assign out_writedata = main_q.writedata;
    assign out_rd        = main_q.rd;
    assign out_regwrite  = main_q.regwrite;
    assign out_memread   = main_q.memread;
    assign out_memwrite  = main_q.memwrite;
    assign out_branch    = main_q.branch;
    assign out_take      = out_valid & main_q.branch & main_q.zero;

endmodule

// File: tb/tb_exmem_buffer.sv
// Self-checking bench for exmem_buffer: directed scenarios plus randomized
// valid/ready/flush traffic, compared against a FIFO-queue reference model.
module tb_exmem_buffer;

    localparam int N = 64;

`ifdef EXMEM_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [N-1:0] result;
        logic         zero;
        logic [N-1:0] writedata;
        logic [4:0]   rd;
        logic         regwrite;
        logic         memread;
        logic         memwrite;
        logic         branch;
    } entry_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_result;
    logic         in_zero;
    logic [N-1:0] in_writedata;
    logic [4:0]   in_rd;
    logic         in_regwrite, in_memread, in_memwrite, in_branch;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_result, out_writedata;
    logic         out_zero;
    logic [4:0]   out_rd;
    logic         out_regwrite, out_memread, out_memwrite, out_branch;
    logic         out_take;

    exmem_buffer #(.N(N)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_zero(in_zero), .in_writedata(in_writedata),
        .in_rd(in_rd), .in_regwrite(in_regwrite), .in_memread(in_memread),
        .in_memwrite(in_memwrite), .in_branch(in_branch),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_writedata(out_writedata),
        .out_zero(out_zero), .out_rd(out_rd), .out_regwrite(out_regwrite),
        .out_memread(out_memread), .out_memwrite(out_memwrite),
        .out_branch(out_branch), .out_take(out_take)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    entry_t model_q[$];
    logic   prev_stall = 1'b0;
    entry_t prev_pay;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic entry_t observed();
        return '{result: out_result, zero: out_zero, writedata: out_writedata,
                 rd: out_rd, regwrite: out_regwrite, memread: out_memread,
                 memwrite: out_memwrite, branch: out_branch};
    endfunction

    function automatic entry_t mk(input logic [N-1:0] res, input logic z, input logic br);
        entry_t e;
        e.result    = res;
        e.zero      = z;
        e.writedata = {$urandom, $urandom};
        e.rd        = 5'($urandom);
        e.regwrite  = 1'($urandom);
        e.memread   = 1'($urandom);
        e.memwrite  = 1'($urandom);
        e.branch    = br;
        return e;
    endfunction

    // One clock cycle: drive inputs after the falling edge, check outputs
    // against the queue model, then advance the model at the rising edge.
    task automatic step(input logic iv, input entry_t e, input logic ordy,
                        input logic fl, output logic accepted);
        logic   exp_rdy, exp_ov, exp_take;
        entry_t head;
        @(negedge clk);
        in_valid     = iv;
        in_result    = e.result;
        in_zero      = e.zero;
        in_writedata = e.writedata;
        in_rd        = e.rd;
        in_regwrite  = e.regwrite;
        in_memread   = e.memread;
        in_memwrite  = e.memwrite;
        in_branch    = e.branch;
        out_ready    = ordy;
        flush        = fl;
        #1;
        exp_rdy  = !fl && ((model_q.size() < CAP) ||
                           (CAP == 1 && ordy));
        exp_ov   = !fl && (model_q.size() > 0);
        head     = (model_q.size() > 0) ? model_q[0] : '0;
        exp_take = exp_ov && head.branch && head.zero;
        check("in_ready", 160'(in_ready), 160'(exp_rdy));
        check("out_valid", 160'(out_valid), 160'(exp_ov));
        check("out_take", 160'(out_take), 160'(exp_take));
        if (exp_ov) begin
            check("payload", 160'(observed()), 160'(head));
            if (prev_stall) begin
                check("stable", 160'(observed()), 160'(prev_pay));
            end
        end
        prev_stall = exp_ov && !ordy;
        prev_pay   = observed();
        accepted   = iv && exp_rdy;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (exp_ov && ordy) void'(model_q.pop_front());
            if (accepted) model_q.push_back(e);
        end
    endtask

    // Presents a list of results in order, advancing only on acceptance.
    task automatic present(input logic [N-1:0] vals[$], input int unsigned max_cyc,
                           input logic [31:0] ordy_mask);
        int unsigned idx = 0;
        logic acc;
        for (int unsigned c = 0; c < max_cyc; c++) begin
            if (idx < vals.size()) begin
                step(1'b1, mk(vals[idx], 1'b0, 1'b0), ordy_mask[c % 32], 1'b0, acc);
                if (acc) idx++;
            end else begin
                step(1'b0, '0, ordy_mask[c % 32], 1'b0, acc);
            end
        end
        check("present_done", 160'(idx), 160'(vals.size()));
    endtask

    initial begin
        logic acc;
        logic [N-1:0] vals[$];
        entry_t e;

        reset = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_result = '1; in_zero = 1'b1; in_writedata = '1; in_rd = '1;
        in_regwrite = 1'b1; in_memread = 1'b1; in_memwrite = 1'b1; in_branch = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 160'(out_valid), 160'(0));
        check("rst_payload", 160'(observed()), 160'(0));
        check("rst_take", 160'(out_take), 160'(0));
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        #1;
        check("rst_in_ready", 160'(in_ready), 160'(1));

        // Streaming 0x10..0x17 with the sink always ready.
        vals.delete();
        for (int unsigned i = 0; i < 8; i++) vals.push_back(N'(64'h10 + i));
        present(vals, 10, 32'hFFFF_FFFF);

        // Back-pressure: sink stalled 4 cycles, then ready.
        vals = '{64'hA, 64'hB, 64'hC};
        present(vals, 10, 32'hFFFF_FFF0);

        // Flush with two entries offered and 0xFF on the input.
        step(1'b1, mk(64'h21, 1'b0, 1'b0), 1'b0, 1'b0, acc);
        step(1'b1, mk(64'h22, 1'b0, 1'b0), 1'b0, 1'b0, acc);
        step(1'b1, mk(64'hFF, 1'b0, 1'b0), 1'b1, 1'b1, acc);
        check("flush_no_accept", 160'(acc), 160'(0));
        step(1'b0, '0, 1'b1, 1'b0, acc);
        check("flush_empty", 160'(out_valid), 160'(0));

        // CBZ taken / not taken.
        step(1'b1, mk(64'h0, 1'b1, 1'b1), 1'b0, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b0, acc);
        check("cbz_taken", 160'(out_take), 160'(1));
        step(1'b1, mk(64'h0, 1'b0, 1'b1), 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b0, acc);
        check("cbz_not_taken", 160'(out_take), 160'(0));
        step(1'b0, '0, 1'b1, 1'b0, acc);

        // Asynchronous reset mid-stream.
        step(1'b1, mk(64'h55, 1'b1, 1'b1), 1'b0, 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", 160'(out_valid), 160'(0));
        check("mid_rst_result", 160'(out_result), 160'(0));
        check("mid_rst_take", 160'(out_take), 160'(0));
        model_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        #1;
        check("mid_rst_ready", 160'(in_ready), 160'(1));

        // Randomized traffic.
        for (int unsigned c = 0; c < 10000; c++) begin
            e = mk({$urandom, $urandom}, 1'($urandom), 1'($urandom));
            step(1'($urandom_range(0, 3) != 0), e, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 63) == 0), acc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
